// File: rtl/int_to_fp_pkg.sv
// Shared class-flag encoding and half-precision format constants, plus the
// converter's state type.
package int_to_fp_pkg;

  localparam int NTYPES         = 6;
  localparam int FLAG_SNAN      = 0;
  localparam int FLAG_QNAN      = 1;
  localparam int FLAG_INFINITY  = 2;
  localparam int FLAG_ZERO      = 3;
  localparam int FLAG_SUBNORMAL = 4;
  localparam int FLAG_NORMAL    = 5;

  localparam int BIAS = 15;
  localparam int EMIN = -14;
  localparam int EMAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/int_to_fp.sv
// Multi-cycle signed integer to IEEE-style float converter: serial left-shift
// normalisation, then one round-to-nearest-even step.
module int_to_fp
  import int_to_fp_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  parameter int NINT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NINT-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_q,
  output logic [NTYPES-1:0]      out_flags
);

  localparam int CW = $clog2(NINT + 1);

  state_e                state_q, state_d;
  logic [NINT-1:0]       mag_q, mag_d;
  logic                  sign_q, sign_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NEXP+NSIG:0]    res_q, res_d;
  logic [NTYPES-1:0]     flags_q, flags_d;

  logic [NINT-1:0]       in_abs;
  logic [NSIG:0]         sig;
  logic                  guard, sticky, round_up;
  logic [NSIG+1:0]       sig_rnd;
  logic [NEXP-1:0]       exp_b;
  logic [NSIG-1:0]       frac;

  // Two's-complement negate as unsigned, so the most negative value stays exact.
  assign in_abs = in_data[NINT-1] ? (~in_data + 1'b1) : in_data;

  assign sig      = mag_q[NINT-1 -: NSIG+1];
  assign guard    = mag_q[NINT-NSIG-2];
  assign sticky   = |mag_q[NINT-NSIG-3:0];
  assign round_up = guard & (sticky | sig[0]);
  assign sig_rnd  = {1'b0, sig} + (NSIG+2)'(round_up);
  // Carry out of rounding means the significand became exactly 2.0.
  assign exp_b    = NEXP'(NINT - 1 + BIAS) - NEXP'(cnt_q) + NEXP'(sig_rnd[NSIG+1]);
  assign frac     = sig_rnd[NSIG+1] ? '0 : sig_rnd[NSIG-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sign_d = in_data[NINT-1];
          mag_d  = in_abs;
          cnt_d  = '0;
          if (in_abs == '0) begin
            res_d              = '0;
            flags_d            = '0;
            flags_d[FLAG_ZERO] = 1'b1;
            state_d            = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[NINT-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ROUND: begin
        res_d                = {sign_q, exp_b, frac};
        flags_d              = '0;
        flags_d[FLAG_NORMAL] = 1'b1;
        state_d              = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_q     = res_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed corner cases, random operands
// against an arithmetic reference model, backpressure and mid-conversion reset.
module tb_int_to_fp;
  import int_to_fp_pkg::*;

  localparam int NEXP = 5;
  localparam int NSIG = 10;
  localparam int NINT = 16;
  localparam int NW   = NEXP + NSIG + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NINT-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NW-1:0]     out_q;
  logic [NTYPES-1:0] out_flags;

  int checks   = 0;
  int failures = 0;

  int_to_fp #(.NEXP(NEXP), .NSIG(NSIG), .NINT(NINT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer value rounded to NSIG fraction bits, nearest-even.
  function automatic void ref_conv(input logic [NINT-1:0] v, output logic [NW-1:0] q,
                                   output logic [NTYPES-1:0] f, output int lat);
    int  m, e, sh, qs, rem, half;
    bit  s;
    f = '0;
    if (v == '0) begin
      q = '0;
      f[FLAG_ZERO] = 1'b1;
      lat = 1;
      return;
    end
    s = v[NINT-1];
    m = s ? (1 << NINT) - int'(v) : int'(v);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    lat = (NINT - 1 - e) + 3;
    if (e <= NSIG) begin
      qs = m << (NSIG - e);
    end else begin
      sh   = e - NSIG;
      qs   = m >> sh;
      rem  = m - (qs << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (qs % 2) == 1)) qs++;
      if (qs == (1 << (NSIG + 1))) begin
        qs = qs >> 1;
        e++;
      end
    end
    q = {s, NEXP'(e + BIAS), NSIG'(qs - (1 << NSIG))};
    f[FLAG_NORMAL] = 1'b1;
  endfunction

  task automatic convert(input logic [NINT-1:0] v, input bit use_tbl, input logic [NW-1:0] tbl_q,
                         input int hold, input bit noise, input string tag);
    logic [NW-1:0]     exp_q, held_q;
    logic [NTYPES-1:0] exp_f, held_f;
    int                exp_lat, edges, waitc, e_fld;
    ref_conv(v, exp_q, exp_f, exp_lat);
    if (use_tbl) exp_q = tbl_q;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = NINT'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ":latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, ":out_q"}, 32'(out_q), 32'(exp_q));
    chk({tag, ":flags"}, 32'(out_flags), 32'(exp_f));
    if (exp_f[FLAG_NORMAL]) begin
      e_fld = int'(out_q[NW-2 -: NEXP]) - BIAS;
      chk({tag, ":exp_range"}, 32'(e_fld >= EMIN && e_fld <= EMAX), 32'd1);
    end
    held_q = out_q;
    held_f = out_flags;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_data  = NINT'($urandom);
      @(posedge clk); #1;
      chk({tag, ":bp_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ":bp_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ":bp_q"}, 32'(out_q), 32'(held_q));
      chk({tag, ":bp_flags"}, 32'(out_flags), 32'(held_f));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ":hs_idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [NINT-1:0] dir_in  [7] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0801, 16'h0803, 16'h0000};
  logic [NW-1:0]   dir_out [7] = '{16'h3C00, 16'hBC00, 16'hF800, 16'h7800, 16'h6800, 16'h6802, 16'h0000};

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:out_q", 32'(out_q), 32'd0);
    chk("rst:flags", 32'(out_flags), 32'd0);

    for (int i = 0; i < 7; i++)
      convert(dir_in[i], 1'b1, dir_out[i], (i == 5) ? 5 : 0, 1'b0, $sformatf("dir%0d", i));

    for (int i = 0; i < 24; i++)
      convert(NINT'($urandom), 1'b0, '0, int'($urandom_range(0, 3)), 1'b1, $sformatf("rnd%0d", i));

    // Reset in the middle of normalising 0x0001.
    in_valid = 1'b1;
    in_data  = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst:out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst:out_q", 32'(out_q), 32'd0);
    chk("mid_rst:flags", 32'(out_flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst:in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst:no_result", 32'(seen), 32'd0);
    convert(16'h0002, 1'b1, 16'h4000, 0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
